// File: rtl/cic_integ_decim.sv
// CIC integrator cascade with a run-time programmable 1-in-R downsampler.
// Feeds the comb stage directly; a new ratio is adopted only at frame boundaries.
module cic_integ_decim #(
    parameter int INP_WIDTH = 16,
    parameter int OUT_WIDTH = 40,
    parameter int CIC_N     = 3,
    parameter int CIC_R_MAX = 64,
    parameter int RATE_W    = $clog2(CIC_R_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [RATE_W-1:0]    decim_rate,
    input  logic [INP_WIDTH-1:0] samp_inp_data,
    input  logic                 samp_inp_str,
    output logic [OUT_WIDTH-1:0] samp_out_data,
    output logic                 samp_out_str,
    output logic                 frame_start
);

    logic [RATE_W-1:0]    rateClamped;
    logic [OUT_WIDTH-1:0] inpExt;

    logic [OUT_WIDTH-1:0] integ_q [CIC_N];
    logic [OUT_WIDTH-1:0] integ_d [CIC_N];
    logic [RATE_W-1:0]    cnt_q, cnt_d;
    logic [RATE_W-1:0]    rate_q, rate_d;
    logic [OUT_WIDTH-1:0] outData_q, outData_d;
    logic                 outStr_q, outStr_d;
    logic                 frameStart_q, frameStart_d;

    logic                 frameLast;
    logic                 decimEvent;

    always_comb begin
        rateClamped = decim_rate;
        if (decim_rate == '0) begin
            rateClamped = RATE_W'(1);
        end else if (decim_rate > RATE_W'(CIC_R_MAX)) begin
            rateClamped = RATE_W'(CIC_R_MAX);
        end
    end

    assign inpExt = OUT_WIDTH'($signed(samp_inp_data));

    // Each stage adds the previous stage's registered value: one adder per stage,
    // wrapping modulo 2^OUT_WIDTH by construction.
    always_comb begin
        for (int k = 0; k < CIC_N; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (samp_inp_str) begin
            integ_d[0] = integ_q[0] + inpExt;
            for (int k = 1; k < CIC_N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    // ">=" keeps the counter from running away should it ever sit past the last phase.
    assign frameLast  = (cnt_q >= rate_q - RATE_W'(1));
    assign decimEvent = samp_inp_str && frameLast;

    always_comb begin
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        outData_d    = outData_q;
        outStr_d     = 1'b0;
        frameStart_d = 1'b0;
        if (samp_inp_str) begin
            frameStart_d = (cnt_q == '0);
            if (frameLast) begin
                cnt_d     = '0;
                rate_d    = rateClamped;
                outData_d = integ_d[CIC_N-1];
                outStr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < CIC_N; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q        <= '0;
            rate_q       <= rateClamped;
            outData_q    <= '0;
            outStr_q     <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            for (int k = 0; k < CIC_N; k++) begin
                integ_q[k] <= integ_d[k];
            end
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            outData_q    <= outData_d;
            outStr_q     <= outStr_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign samp_out_data = outData_q;
    assign samp_out_str  = outStr_q;
    assign frame_start   = frameStart_q;

    // decimEvent is only a readability alias of the reload condition.
    logic unusedEvent;
    assign unusedEvent = decimEvent;

endmodule
